// File: rtl/ama_riscv_fetch_pkg.sv
// Shared fetch/decoder definitions: next-PC select encodings, NOP and reset vector.
package ama_riscv_fetch_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      PC_SEL_INC4       = 2'd0,
      PC_SEL_ALU        = 2'd1,
      PC_SEL_BP         = 2'd2,
      PC_SEL_START_ADDR = 2'd3
   } pc_sel_t;

   localparam logic [XLEN-1:0] NOP                  = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

   // Redirect targets are always word aligned.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return addr & ~(XLEN'(3));
   endfunction

endpackage

// File: rtl/ama_riscv_pc_mux.sv
// Combinational next-PC select; holds the current PC when pc_we is low.
module ama_riscv_pc_mux
   import ama_riscv_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
   input  logic [1:0]      pc_sel,
   input  logic            pc_we,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] alu_out,
   output logic [XLEN-1:0] pc_next_c
);

   always_comb begin
      pc_next_c = pc;
      if (pc_we) begin
         case (pc_sel_t'(pc_sel))
            PC_SEL_INC4:       pc_next_c = pc + XLEN'(4);
            PC_SEL_ALU:        pc_next_c = align_word(alu_out);
            // Reserved select; sequential fetch.
            PC_SEL_BP:         pc_next_c = pc + XLEN'(4);
            PC_SEL_START_ADDR: pc_next_c = RESET_VECTOR;
            default:           pc_next_c = pc + XLEN'(4);
         endcase
      end
   end

endmodule

// File: rtl/ama_riscv_fetch.sv
// IF stage: PC register, IMEM addressing, IF/ID instruction/PC registers and
// the post-reset pipeline clear sequence.
module ama_riscv_fetch
   import ama_riscv_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
   parameter int unsigned     IMEM_AW      = 14
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         pc_sel,
   input  logic               pc_we,
   input  logic               stall_if,
   input  logic               clear_if,
   input  logic [XLEN-1:0]    alu_out,
   input  logic [XLEN-1:0]    imem_rdata,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [XLEN-1:0]    pc,
   output logic [XLEN-1:0]    inst_id,
   output logic [XLEN-1:0]    pc_id,
   output logic [XLEN-1:0]    pc_inc4_id,
   output logic               rst_seq_id,
   output logic               rst_seq_ex,
   output logic               rst_seq_mem
);

   logic [XLEN-1:0] pc_mux_out;
   logic [XLEN-1:0] pc_next;
   logic            stall_q;
   logic [2:0]      rs;

   ama_riscv_pc_mux #(
      .RESET_VECTOR (RESET_VECTOR)
   ) u_pc_mux (
      .pc_sel    (pc_sel),
      .pc_we     (pc_we),
      .pc        (pc),
      .alu_out   (alu_out),
      .pc_next_c (pc_mux_out)
   );

   // Reset overrides the select so IMEM is already fetching the reset vector
   // when reset releases; nothing computed before reset can leak through.
   assign pc_next   = rst ? RESET_VECTOR : pc_mux_out;
   assign imem_addr = pc_next[IMEM_AW+1:2];

   always_ff @(posedge clk) begin
      pc <= pc_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= 1'b0;
         rs      <= 3'b111;
      end else begin
         stall_q <= stall_if;
         rs      <= {rs[1:0], 1'b0};
      end
   end

   // Bubble is decided one edge early so inst_id is NOP exactly while
   // stall_q, clear_q or rst_seq_id would be high.
   always_ff @(posedge clk) begin
      if (rst || stall_if || clear_if) inst_id <= NOP;
      else                             inst_id <= imem_rdata;
   end

   always_ff @(posedge clk) begin
      if (rst)           pc_id <= RESET_VECTOR;
      else if (!stall_q) pc_id <= pc;
   end

   assign pc_inc4_id  = pc_id + XLEN'(4);
   assign rst_seq_id  = rs[0];
   assign rst_seq_ex  = rs[1];
   assign rst_seq_mem = rs[2];

endmodule

// File: tb/tb_ama_riscv_fetch.sv
// Directed bench for ama_riscv_fetch with a synchronous IMEM model.
module tb_ama_riscv_fetch;
   import ama_riscv_fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  pc_sel;
   logic        pc_we;
   logic        stall_if;
   logic        clear_if;
   logic [31:0] alu_out;
   logic [31:0] imem_rdata;
   logic [13:0] imem_addr;
   logic [31:0] pc;
   logic [31:0] inst_id;
   logic [31:0] pc_id;
   logic [31:0] pc_inc4_id;
   logic        rst_seq_id;
   logic        rst_seq_ex;
   logic        rst_seq_mem;

   int ncmp = 0;
   int nerr = 0;

   ama_riscv_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .pc_sel      (pc_sel),
      .pc_we       (pc_we),
      .stall_if    (stall_if),
      .clear_if    (clear_if),
      .alu_out     (alu_out),
      .imem_rdata  (imem_rdata),
      .imem_addr   (imem_addr),
      .pc          (pc),
      .inst_id     (inst_id),
      .pc_id       (pc_id),
      .pc_inc4_id  (pc_inc4_id),
      .rst_seq_id  (rst_seq_id),
      .rst_seq_ex  (rst_seq_ex),
      .rst_seq_mem (rst_seq_mem)
   );

   always #5 clk = ~clk;

   // Word 0 holds addi x1,x0,5; every other word encodes its byte address.
   function automatic logic [31:0] imem_word(input logic [13:0] a);
      if (a == 14'd0) return 32'h0050_0093;
      return {16'hA5A5, a, 2'b00};
   endfunction

   always @(posedge clk) imem_rdata <= imem_word(imem_addr);

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [1:0] sel, input logic st,
                        input logic cl, input logic [31:0] alu);
      pc_we = we; pc_sel = sel; stall_if = st; clear_if = cl; alu_out = alu;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, PC_SEL_INC4, 1'b0, 1'b0, 32'h0);
      cyc(); cyc();
      ncmp++; if (pc !== 32'h0) begin nerr++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
      ncmp++; if (imem_addr !== 14'h0) begin nerr++; $display("FAIL reset_imem_addr: got %h want %h", imem_addr, 14'h0); end
      ncmp++; if (pc_id !== 32'h0) begin nerr++; $display("FAIL reset_pc_id: got %h want %h", pc_id, 32'h0); end
      ncmp++; if (inst_id !== NOP) begin nerr++; $display("FAIL reset_inst_id: got %h want %h", inst_id, NOP); end
      ncmp++; if ({rst_seq_id, rst_seq_ex, rst_seq_mem} !== 3'b111) begin nerr++; $display("FAIL reset_seq: got %b want %b", {rst_seq_id, rst_seq_ex, rst_seq_mem}, 3'b111); end
   endtask

   task automatic test_reset_release();
      rst = 1'b0;
      drive(1'b1, PC_SEL_INC4, 1'b0, 1'b0, 32'h0);
      #1;
      ncmp++; if (inst_id !== NOP) begin nerr++; $display("FAIL c0_inst_id: got %h want %h", inst_id, NOP); end
      ncmp++; if ({rst_seq_id, rst_seq_ex, rst_seq_mem} !== 3'b111) begin nerr++; $display("FAIL c0_seq: got %b want %b", {rst_seq_id, rst_seq_ex, rst_seq_mem}, 3'b111); end
      cyc();
      ncmp++; if (inst_id !== 32'h0050_0093) begin nerr++; $display("FAIL c1_inst_id: got %h want %h", inst_id, 32'h0050_0093); end
      ncmp++; if (pc_id !== 32'h0) begin nerr++; $display("FAIL c1_pc_id: got %h want %h", pc_id, 32'h0); end
      ncmp++; if (pc !== 32'h4) begin nerr++; $display("FAIL c1_pc: got %h want %h", pc, 32'h4); end
      ncmp++; if ({rst_seq_id, rst_seq_ex, rst_seq_mem} !== 3'b011) begin nerr++; $display("FAIL c1_seq: got %b want %b", {rst_seq_id, rst_seq_ex, rst_seq_mem}, 3'b011); end
   endtask

   task automatic test_straight_line();
      logic [31:0] exp_pc;
      logic [2:0]  exp_seq;
      for (int k = 1; k <= 2; k++) begin
         cyc();
         exp_pc  = 32'(4 * k);
         exp_seq = (k == 1) ? 3'b001 : 3'b000;
         ncmp++; if (pc_id !== exp_pc) begin nerr++; $display("FAIL seq_pc_id[%0d]: got %h want %h", k, pc_id, exp_pc); end
         ncmp++; if (pc_inc4_id !== exp_pc + 32'd4) begin nerr++; $display("FAIL seq_pc_inc4[%0d]: got %h want %h", k, pc_inc4_id, exp_pc + 32'd4); end
         ncmp++; if (inst_id !== {16'hA5A5, exp_pc[15:0]}) begin nerr++; $display("FAIL seq_inst[%0d]: got %h want %h", k, inst_id, {16'hA5A5, exp_pc[15:0]}); end
         ncmp++; if ({rst_seq_id, rst_seq_ex, rst_seq_mem} !== exp_seq) begin nerr++; $display("FAIL seq_strobes[%0d]: got %b want %b", k, {rst_seq_id, rst_seq_ex, rst_seq_mem}, exp_seq); end
      end
   endtask

   task automatic test_branch_stall();
      drive(1'b0, PC_SEL_INC4, 1'b1, 1'b0, 32'h0);
      cyc();
      ncmp++; if (inst_id !== NOP) begin nerr++; $display("FAIL br_inst_nop: got %h want %h", inst_id, NOP); end
      ncmp++; if (pc !== 32'hC) begin nerr++; $display("FAIL br_pc_hold: got %h want %h", pc, 32'hC); end
      drive(1'b1, PC_SEL_INC4, 1'b0, 1'b0, 32'h0);
      cyc();
      ncmp++; if (inst_id !== 32'hA5A5_000C) begin nerr++; $display("FAIL br_resume_inst: got %h want %h", inst_id, 32'hA5A5_000C); end
      ncmp++; if (pc_id !== 32'hC) begin nerr++; $display("FAIL br_resume_pc_id: got %h want %h", pc_id, 32'hC); end
      cyc();
      ncmp++; if (pc_id !== 32'h10) begin nerr++; $display("FAIL br_next_pc_id: got %h want %h", pc_id, 32'h10); end
      ncmp++; if (inst_id !== 32'hA5A5_0010) begin nerr++; $display("FAIL br_next_inst: got %h want %h", inst_id, 32'hA5A5_0010); end
   endtask

   task automatic test_jump_redirect();
      drive(1'b1, PC_SEL_ALU, 1'b0, 1'b1, 32'h40);
      #1;
      ncmp++; if (imem_addr !== 14'h10) begin nerr++; $display("FAIL jmp_imem_addr: got %h want %h", imem_addr, 14'h10); end
      cyc();
      ncmp++; if (inst_id !== NOP) begin nerr++; $display("FAIL jmp_inst_nop: got %h want %h", inst_id, NOP); end
      ncmp++; if (pc !== 32'h40) begin nerr++; $display("FAIL jmp_pc: got %h want %h", pc, 32'h40); end
      drive(1'b1, PC_SEL_INC4, 1'b0, 1'b0, 32'h0);
      cyc();
      ncmp++; if (inst_id !== 32'hA5A5_0040) begin nerr++; $display("FAIL jmp_target_inst: got %h want %h", inst_id, 32'hA5A5_0040); end
      ncmp++; if (pc_id !== 32'h40) begin nerr++; $display("FAIL jmp_target_pc_id: got %h want %h", pc_id, 32'h40); end
      ncmp++; if (pc_inc4_id !== 32'h44) begin nerr++; $display("FAIL jmp_pc_inc4: got %h want %h", pc_inc4_id, 32'h44); end
   endtask

   task automatic test_wrap_align();
      drive(1'b1, PC_SEL_ALU, 1'b0, 1'b0, 32'hFFFF_FFFC);
      cyc();
      ncmp++; if (pc !== 32'hFFFF_FFFC) begin nerr++; $display("FAIL wrap_pc_top: got %h want %h", pc, 32'hFFFF_FFFC); end
      drive(1'b1, PC_SEL_INC4, 1'b0, 1'b0, 32'h0);
      cyc();
      ncmp++; if (pc !== 32'h0) begin nerr++; $display("FAIL wrap_pc_zero: got %h want %h", pc, 32'h0); end
      ncmp++; if (pc_inc4_id !== 32'h0) begin nerr++; $display("FAIL wrap_pc_inc4: got %h want %h", pc_inc4_id, 32'h0); end
      ncmp++; if (inst_id !== 32'hA5A5_FFFC) begin nerr++; $display("FAIL wrap_inst: got %h want %h", inst_id, 32'hA5A5_FFFC); end
      drive(1'b1, PC_SEL_ALU, 1'b0, 1'b0, 32'h43);
      #1;
      ncmp++; if (imem_addr !== 14'h10) begin nerr++; $display("FAIL align_imem_addr: got %h want %h", imem_addr, 14'h10); end
      cyc();
      ncmp++; if (pc !== 32'h40) begin nerr++; $display("FAIL align_pc: got %h want %h", pc, 32'h40); end
   endtask

   task automatic test_stall_clear_redirect();
      drive(1'b1, PC_SEL_ALU, 1'b1, 1'b1, 32'h80);
      cyc();
      ncmp++; if (pc !== 32'h80) begin nerr++; $display("FAIL sc_pc_redirect: got %h want %h", pc, 32'h80); end
      ncmp++; if (inst_id !== NOP) begin nerr++; $display("FAIL sc_inst_nop: got %h want %h", inst_id, NOP); end
      ncmp++; if (pc_id !== 32'h40) begin nerr++; $display("FAIL sc_pc_id: got %h want %h", pc_id, 32'h40); end
      drive(1'b1, PC_SEL_INC4, 1'b0, 1'b0, 32'h0);
      cyc();
      ncmp++; if (pc_id !== 32'h40) begin nerr++; $display("FAIL sc_pc_id_hold: got %h want %h", pc_id, 32'h40); end
      ncmp++; if (inst_id !== 32'hA5A5_0080) begin nerr++; $display("FAIL sc_inst_target: got %h want %h", inst_id, 32'hA5A5_0080); end
      ncmp++; if (pc !== 32'h84) begin nerr++; $display("FAIL sc_pc_next: got %h want %h", pc, 32'h84); end
   endtask

   task automatic test_stall_reset();
      drive(1'b0, PC_SEL_INC4, 1'b1, 1'b0, 32'h0);
      #1;
      ncmp++; if (imem_addr !== 14'h21) begin nerr++; $display("FAIL st_imem_reread: got %h want %h", imem_addr, 14'h21); end
      cyc();
      ncmp++; if (pc !== 32'h84) begin nerr++; $display("FAIL st_pc_hold: got %h want %h", pc, 32'h84); end
      ncmp++; if (inst_id !== NOP) begin nerr++; $display("FAIL st_inst_nop: got %h want %h", inst_id, NOP); end
      rst = 1'b1;
      drive(1'b1, PC_SEL_ALU, 1'b1, 1'b0, 32'h100);
      #1;
      ncmp++; if (imem_addr !== 14'h0) begin nerr++; $display("FAIL rs_imem_addr: got %h want %h", imem_addr, 14'h0); end
      cyc();
      ncmp++; if (pc !== 32'h0) begin nerr++; $display("FAIL rs_pc: got %h want %h", pc, 32'h0); end
      ncmp++; if (pc_id !== 32'h0) begin nerr++; $display("FAIL rs_pc_id: got %h want %h", pc_id, 32'h0); end
      ncmp++; if ({rst_seq_id, rst_seq_ex, rst_seq_mem} !== 3'b111) begin nerr++; $display("FAIL rs_seq: got %b want %b", {rst_seq_id, rst_seq_ex, rst_seq_mem}, 3'b111); end
      rst = 1'b0;
      drive(1'b1, PC_SEL_INC4, 1'b0, 1'b0, 32'h0);
      #1;
      ncmp++; if (inst_id !== NOP) begin nerr++; $display("FAIL rs_c0_inst: got %h want %h", inst_id, NOP); end
      cyc();
      ncmp++; if (inst_id !== 32'h0050_0093) begin nerr++; $display("FAIL rs_c1_inst: got %h want %h", inst_id, 32'h0050_0093); end
      ncmp++; if (pc_id !== 32'h0) begin nerr++; $display("FAIL rs_c1_pc_id: got %h want %h", pc_id, 32'h0); end
      ncmp++; if ({rst_seq_id, rst_seq_ex, rst_seq_mem} !== 3'b011) begin nerr++; $display("FAIL rs_c1_seq: got %b want %b", {rst_seq_id, rst_seq_ex, rst_seq_mem}, 3'b011); end
   endtask

   initial begin
      test_reset();
      test_reset_release();
      test_straight_line();
      test_branch_stall();
      test_jump_redirect();
      test_wrap_align();
      test_stall_clear_redirect();
      test_stall_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/ama_riscv_fetch.md
AMA_RISCV_FETCH -- requirements
Module: ama_riscv_fetch

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, start address loaded into the PC.
REQ-002 Parameter IMEM_AW, default 14, IMEM word-address width.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 pc_sel  input  2  next-PC select from the decoder: INC4=2'd0, ALU=2'd1, BP=2'd2 (reserved, treated as INC4), START_ADDR=2'd3.
REQ-006 pc_we  input  1  PC write enable from the decoder.
REQ-007 stall_if  input  1  fetch stall request from the decoder.
REQ-008 clear_if  input  1  flush request for the instruction entering ID.
REQ-009 alu_out  input  32  redirect target from EX (branch/jump).
REQ-010 imem_rdata  input  32  synchronous IMEM read data, valid one cycle after the address.
REQ-011 imem_addr  output  IMEM_AW  IMEM word address, driven from next-PC bits [IMEM_AW+1:2].
REQ-012 pc  output  32  PC of the instruction currently being read (IF).
REQ-013 inst_id  output  32  instruction presented to the decoder.
REQ-014 pc_id  output  32  PC associated with inst_id.
REQ-015 pc_inc4_id  output  32  pc_id + 4, used for the JAL/JALR write-back.
REQ-016 rst_seq_id, rst_seq_ex, rst_seq_mem  output  1 each  post-reset pipeline clear strobes.

Function
REQ-017 pc_next: pc_we=0 -> pc; otherwise INC4/BP -> pc+4, ALU -> alu_out, START_ADDR -> RESET_VECTOR.
REQ-018 pc <= pc_next on every non-reset edge; imem_addr = pc_next[IMEM_AW+1:2] combinationally, so imem_rdata in cycle N+1 corresponds to pc in cycle N+1.
REQ-019 PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0; alu_out bits [1:0] are forced to 0.
REQ-020 Bubble condition: stall_q OR clear_q OR rst_seq_id, where stall_q and clear_q are stall_if and clear_if registered one cycle.
REQ-021 Under bubble, inst_id = NOP 32'h0000_0013; otherwise inst_id = imem_rdata.
REQ-022 pc_id tracks pc with one cycle of delay and holds while stall_q=1.
REQ-023 pc_inc4_id = pc_id + 4, computed combinationally.
REQ-024 With stall_if=1 and pc_we=0, the PC holds and IMEM re-reads the same word; no instruction is lost or duplicated into ID.
REQ-025 If clear_if and stall_if are both set, clear takes precedence for inst_id (NOP); the PC still follows pc_we/pc_sel.
REQ-026 If pc_sel=ALU and pc_we=1 are seen in the same cycle as stall_if, the redirect is taken; pc_we alone gates the PC.
REQ-027 Reset sequence: 3-bit shift register rs is set to 3'b111 in reset, otherwise rs <= {rs[1:0],1'b0}.
REQ-028 Strobe mapping: rst_seq_id=rs[0] (1 cycle after rst), rst_seq_ex=rs[1] (2 cycles), rst_seq_mem=rs[2] (3 cycles).
REQ-029 Latency: the instruction at address A reaches inst_id one cycle after pc=A, with no stall.

Reset
REQ-030 In reset: pc=RESET_VECTOR, so imem_addr=RESET_VECTOR[IMEM_AW+1:2]; pc_id=RESET_VECTOR; stall_q=0; clear_q=0; rs=3'b111.
REQ-031 inst_id reads NOP throughout reset and on the first cycle after it.
REQ-032 rst asserted mid-operation (stall or redirect in flight) discards all state on the next edge; no partial redirect survives.

Structure
REQ-033 PC_SEL_* encodings, NOP encoding and RESET_VECTOR default live in the shared defines file used by the decoder.
REQ-034 One sub-module, ama_riscv_pc_mux (combinational next-PC select), is instantiated; all other logic is flat.

Verification
REQ-035 Reset release with IMEM[0]=0x00500093 -> cycle 0: inst_id=NOP, rst_seq_id/ex/mem=1/1/1; cycle 1: inst_id=0x00500093, pc_id=0; rst_seq_ex clears after cycle 1, rst_seq_mem after cycle 2.
REQ-036 Straight-line code from 0 -> pc_id steps by 4 each cycle (0,4,8,C) and pc_inc4_id=pc_id+4.
REQ-037 Branch at 0x8 in ID drives stall_if=1, pc_we=0 for 1 cycle -> next inst_id=NOP, pc holds at 0xC, then resumes from 0xC.
REQ-038 Jump redirect with pc_sel=ALU, alu_out=0x40, clear_if=1 -> next inst_id=NOP; the following cycle inst_id=IMEM[0x40], pc_id=0x40.
REQ-039 pc=32'hFFFF_FFFC with INC4 -> pc=0; alu_out=0x43 -> pc=0x40.
REQ-040 rst asserted during a stall -> pc=RESET_VECTOR and rs=3'b111 after the edge; the fetch sequence restarts per REQ-035.
